// File: rtl/unidade_busca_if.sv
// Fetch-stage bundle: next-PC/control inputs, instruction memory handshake and the pc/inst pair
// presented downstream. The master modport is the fetch unit; slave is everything around it.
interface unidade_busca_if;
  logic [31:0] prox_pc;
  logic        avanca;
  logic        halt;
  logic        mem_ready;
  logic [0:31] mem_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] pc;
  logic [0:31] inst;
  logic        inst_valid;
  logic        halted;
  logic        fault;
  logic [31:0] num_inst;

  modport master (
    input  prox_pc, avanca, halt, mem_ready, mem_data,
    output mem_req, mem_addr, pc, inst, inst_valid, halted, fault, num_inst
  );

  modport slave (
    output prox_pc, avanca, halt, mem_ready, mem_data,
    input  mem_req, mem_addr, pc, inst, inst_valid, halted, fault, num_inst
  );
endinterface

// File: rtl/unidade_busca.sv
// Instruction fetch stage: holds the PC, fetches inst over a req/ready handshake, holds it
// stable until the control unit commits the next PC; supports halt, memory timeout and a fetch counter.
module unidade_busca #(
  parameter logic [31:0] PC_INICIAL  = 32'd0,
  parameter int          MEM_TIMEOUT = 15
) (
  input logic             clk,
  input logic             reset,
  unidade_busca_if.master bus
);

  typedef enum logic [1:0] {ESPERA, PRONTA, PARADA, ERRO} estado_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  estado_t     r_estado;
  estado_t     w_prox_estado;
  logic [31:0] r_pc;
  logic [0:31] r_inst;
  logic [31:0] r_num_inst;
  logic [7:0]  r_cnt_espera;
  logic        w_timeout;

  // Fault fires on the MEM_TIMEOUT-th consecutive edge with ready low.
  assign w_timeout = (r_estado == ESPERA) && !bus.mem_ready && (r_cnt_espera == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_estado <= ESPERA;
    else       r_estado <= w_prox_estado;
  end

  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      ESPERA: begin
        if (bus.mem_ready)  w_prox_estado = PRONTA;
        else if (w_timeout) w_prox_estado = ERRO;
      end
      PRONTA: begin
        if (bus.avanca) w_prox_estado = bus.halt ? PARADA : ESPERA;
      end
      PARADA: begin
        if (!bus.halt) w_prox_estado = ESPERA;
      end
      default: w_prox_estado = ERRO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= PC_INICIAL;
      r_inst       <= '0;
      r_num_inst   <= '0;
      r_cnt_espera <= '0;
    end else begin
      case (r_estado)
        ESPERA: begin
          if (bus.mem_ready) begin
            r_inst       <= bus.mem_data;
            r_num_inst   <= r_num_inst + 32'd1;
            r_cnt_espera <= '0;
          end else begin
            r_cnt_espera <= r_cnt_espera + 8'd1;
          end
        end
        PRONTA: begin
          if (bus.avanca) r_pc <= bus.prox_pc;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req    = (r_estado == ESPERA);
  assign bus.mem_addr   = r_pc;
  assign bus.pc         = r_pc;
  assign bus.inst       = r_inst;
  assign bus.inst_valid = (r_estado == PRONTA);
  assign bus.halted     = (r_estado == PARADA);
  assign bus.fault      = (r_estado == ERRO);
  assign bus.num_inst   = r_num_inst;

endmodule

// File: doc/unidade_busca.md
# unidade_busca

Instruction fetch stage of the processor. Holds the architectural program counter, fetches the instruction word at `pc` from instruction memory through a request/ready handshake, and presents the stable `pc`/`inst` pair to the next-PC unit and the decode fields. When the control unit signals completion, it loads the computed next PC. Supports halt at instruction boundaries, a memory-timeout fault, and a retired-fetch counter.

## Interface

**Parameters**
- `PC_INICIAL`, default 32'd0: PC value loaded on reset.
- `MEM_TIMEOUT`, default 15: cycles `mem_ready` may stay low in ESPERA before a fault is raised (range 1..255).

**Ports**
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `prox_pc` in 32: next PC from the next-PC unit.
- `avanca` in 1: current instruction complete; commit `prox_pc`.
- `halt` in 1: stop fetching at the next instruction boundary.
- `mem_ready` in 1: instruction memory has `mem_data` valid this cycle.
- `mem_data` in 32: instruction word; bit 0 is the MSB (same `[0:31]` ordering as `inst`).
- `mem_req` out 1: fetch request.
- `mem_addr` out 32: fetch address (word address).
- `pc` out 32: current PC.
- `inst` out [0:31]: latched instruction.
- `inst_valid` out 1: `inst` corresponds to `pc` and is stable.
- `halted` out 1: fetch is stopped by `halt`.
- `fault` out 1: memory timeout occurred (sticky).
- `num_inst` out 32: count of completed fetches.

## Operation

**States:** ESPERA (fetch outstanding), PRONTA (instruction held), PARADA (halted), ERRO (fault).

**Reset (async, any state, mid-fetch included):**
- State goes to ESPERA.
- `pc` = PC_INICIAL.
- `inst` = 0, `inst_valid` = 0, `halted` = 0, `fault` = 0, `num_inst` = 0, timeout counter = 0.
- An outstanding request is abandoned.

**Outputs:**
- `mem_req` = (state == ESPERA), combinational.
- `mem_addr` = `pc`.
- `halted` = (state == PARADA).
- `fault` = (state == ERRO).
- `inst_valid` = (state == PRONTA).

**ESPERA:**
- If `mem_ready` = 1:
  - `inst` <= `mem_data`.
  - `num_inst` <= `num_inst` + 1 (wraps mod 2^32).
  - Timeout counter cleared; next state PRONTA.
- Else, the timeout counter increments. When it reaches MEM_TIMEOUT with `mem_ready` still low, the next state is ERRO.
- `halt` and `avanca` are ignored in ESPERA. A fetch is never abandoned except by reset.

**PRONTA:**
- If `avanca` = 1:
  - `pc` <= `prox_pc`, taken unmodified; any 32-bit value is legal and there is no wrap check.
  - Next state is PARADA if `halt` = 1, else ESPERA.
- If `avanca` = 0, hold. `pc` and `inst` are unchanged regardless of `halt`.

**PARADA:**
- `mem_req` = 0 and `pc` is held.
- When `halt` = 0, the next state is ESPERA and the fetch restarts at the held `pc`.

**ERRO:**
- `mem_req` = 0 and all outputs are frozen.
- Exit only by reset.

**Other rules:**
- `mem_ready` outside ESPERA is ignored. `mem_data` is sampled only on the ESPERA+`mem_ready` edge.

## Timing

- Reset release: `mem_req` = 1 with `mem_addr` = PC_INICIAL in the first cycle.
- Zero-wait memory (`mem_ready` high in the request cycle): `inst_valid` rises on the next edge. Fetch latency is 1 cycle plus memory wait cycles.
- `avanca` sampled high in PRONTA: the new `pc` and `mem_req` = 1 appear the following cycle. Peak throughput is 1 instruction per 2 cycles.
- `inst` and `pc` are stable for the whole PRONTA interval, so the downstream combinational next-PC logic sees constant inputs.
- Timeout: `fault` rises exactly MEM_TIMEOUT cycles after entering ESPERA with `mem_ready` held low.
- `halt` asserted together with `avanca` in PRONTA: PARADA the next cycle, with `pc` = `prox_pc` and no request issued.

## Test plan

- **Reset and first fetch:** PC_INICIAL = 0; release reset with `mem_ready` = 1 and `mem_data` = 32'hA5000001 -> cycle 0 `mem_req` = 1, `mem_addr` = 0; cycle 1 `inst` = 32'hA5000001, `inst_valid` = 1, `num_inst` = 1.
- **Sequential advance:** in PRONTA with `pc` = 5, `prox_pc` = 6, `avanca` = 1 -> next cycle `pc` = 6, `mem_req` = 1, `inst_valid` = 0. Also hold `avanca` = 0 for 10 cycles -> `pc`/`inst` unchanged.
- **Wait states and timeout:** MEM_TIMEOUT = 15 with `mem_ready` low 14 cycles then high -> fetch completes, no fault. Hold `mem_ready` low 15 cycles -> `fault` = 1, `mem_req` = 0, sticky until reset.
- **Halt at boundary:** assert `halt` during ESPERA -> fetch still completes and PRONTA is entered. Then `avanca` = 1 with `prox_pc` = 32'h20 -> `halted` = 1, `pc` = 32'h20, `mem_req` = 0. Drop `halt` -> next cycle `mem_req` = 1, `mem_addr` = 32'h20.
- **Reset mid-fetch:** assert `reset` asynchronously while in ESPERA with `pc` = 32'h40 -> outputs immediately return to reset values (`pc` = PC_INICIAL, `num_inst` = 0), without waiting for a clock edge.
- **Branch target and counter wrap:** `prox_pc` = 32'hFFFFFFFF accepted verbatim. Preload `num_inst` to 32'hFFFFFFFF via repeated fetches or a forced state, then one fetch -> `num_inst` wraps to 0.
